four_operand_accum_seq: RTL and testbench
=========================================

FOUR_OPERAND_ACCUM_SEQ -- requirements
Module: four_operand_accum_seq

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; no other clock or reset SHALL exist.
REQ-002 Parameter ACC_W, default 12: accumulator and result width in bits; legal range 9..16.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 in_data  input  6  unsigned operand.
REQ-008 in_last  input  1  beat is the final operand of the frame.
REQ-009 out_valid  output  1  frame result present.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_sum  output  ACC_W  frame sum modulo 2^ACC_W.
REQ-012 out_ovf  output  1  frame sum exceeded 2^ACC_W-1.

Function
REQ-013 Beat accepted when in_valid and in_ready are both high at a rising edge; in_ready SHALL NOT depend combinationally on in_valid.
REQ-014 States: FILL, SUM, DONE; reset state is FILL.
REQ-015 FILL: in_ready=1; accepted beat writes slot[idx], idx increments (0..3).
REQ-016 FILL->SUM when the accepted beat has idx==3 or in_last=1; the captured last flag is held for SUM.
REQ-017 Slots not written in the current group SHALL read as 0 (partial group zero-padded).
REQ-018 SUM lasts exactly one cycle, in_ready=0; the four slots feed the four-input adder with cin=0; acc <= acc + {cout,e} (9-bit group sum, max 252).
REQ-019 In SUM, a carry out of bit ACC_W-1 SHALL set a sticky ovf flag; acc wraps modulo 2^ACC_W.
REQ-020 SUM->DONE if the last flag is set; otherwise SUM->FILL with idx=0 and all slots cleared.
REQ-021 DONE: out_valid=1, out_sum=acc, out_ovf=ovf, in_ready=0; values stable while out_valid=1 and out_ready=0.
REQ-022 DONE->FILL on out_ready=1; same edge clears acc, ovf, idx and slots.
REQ-023 Latency: last beat accepted at edge t -> out_valid high in the cycle after edge t+1; next frame beat accepted no earlier than the edge after the result handshake.
REQ-024 Throughput: a full group accepts 4 beats in 4 consecutive cycles, then 1 SUM bubble cycle.
REQ-025 A frame of one beat with in_last=1 SHALL produce out_sum=in_data.
REQ-026 in_data=0 beats are counted as ordinary operands; no empty frame exists (a frame always has >=1 beat).
REQ-027 out_valid and in_ready SHALL never be high in the same cycle.

Reset
REQ-028 On rst=1 at an edge: state=FILL, idx=0, slots=0, acc=0, ovf=0.
REQ-029 Reset values of outputs: in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
REQ-030 Reset in any state, including mid-group or with a pending result, SHALL discard all partial and pending data; no beat is accepted on the reset edge.

Structure
REQ-031 Shared package holds OPND_W=6, GRP_N=4, GRP_SUM_W=9, default ACC_W=12 and the FILL/SUM/DONE state encoding.
REQ-032 Exactly one sub-module: six_bits_four_inputs_adder, instantiated once, cin tied 0; its output is consumed only in SUM.
REQ-033 All other logic (FSM, slots, index, accumulator, overflow) is in this module, fully synchronous to clk.

Verification
REQ-034 Beats 10,20,30,40 (last on 40), out_ready=1 -> out_valid two cycles after last acceptance, out_sum=100, out_ovf=0.
REQ-035 Beats 63,63,63,63,5,6 (last on 6) -> two SUM cycles, out_sum=263, in_ready low exactly in each SUM cycle and in DONE.
REQ-036 17 groups of 63 (68 beats, last on beat 68), ACC_W=12 -> 17*252=4284, out_sum=188, out_ovf=1.
REQ-037 Single beat 7 with last, out_ready held low 5 cycles -> out_valid, out_sum=7 stable 5 cycles, in_ready=0 throughout; accepted on out_ready=1.
REQ-038 rst asserted after 2 beats of a group, then frame 1,2 (last on 2) -> out_sum=3 (pre-reset beats discarded), outputs at reset values in cycle after reset edge.
REQ-039 Random in_valid/out_ready gaps over 1000 frames vs. reference sum model -> every out_sum/out_ovf matches, no beat lost or duplicated.

Source files
------------

// File: rtl/four_operand_accum_seq_pkg.sv
// four_operand_accum_seq_pkg: shared widths and FSM encoding for the grouped accumulator
package four_operand_accum_seq_pkg;
  localparam int OPND_W = 6;
  localparam int GRP_N = 4;
  localparam int GRP_SUM_W = 9;
  localparam int ACC_W_DEF = 12;
  typedef enum logic [1:0] {FILL = 2'd0, SUM = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/six_bits_four_inputs_adder.sv
// six_bits_four_inputs_adder: adds four 6-bit operands plus carry-in into {cout,e}
module six_bits_four_inputs_adder (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic [5:0] c,
  input  logic [5:0] d,
  input  logic       cin,
  output logic [7:0] e,
  output logic       cout
);
  assign {cout, e} = {3'b0, a} + {3'b0, b} + {3'b0, c} + {3'b0, d} + {8'b0, cin};
endmodule

// File: rtl/four_operand_accum_seq.sv
// four_operand_accum_seq: collects operands in groups of four and accumulates each frame's sum
module four_operand_accum_seq
  import four_operand_accum_seq_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  state_t state;
  logic [1:0] idx;
  logic [GRP_N-1:0][OPND_W-1:0] slot;
  logic last_q;
  logic [ACC_W-1:0] acc;
  logic ovf;
  logic [GRP_SUM_W-2:0] e;
  logic cout;
  logic [ACC_W:0] nxt;
  six_bits_four_inputs_adder u_add (
    .a(slot[0]),
    .b(slot[1]),
    .c(slot[2]),
    .d(slot[3]),
    .cin(1'b0),
    .e(e),
    .cout(cout)
  );
  // extra top bit of nxt is the carry out of the accumulator
  assign nxt = {1'b0, acc} + {{(ACC_W - GRP_SUM_W + 1){1'b0}}, cout, e};
  assign in_ready = state == FILL;
  assign out_valid = state == DONE;
  assign out_sum = acc;
  assign out_ovf = ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx <= '0;
      slot <= '0;
      last_q <= 1'b0;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        FILL: if (in_valid) begin
          slot[idx] <= in_data;
          idx <= idx + 2'd1;
          if (idx == 2'd3 || in_last) begin
            state <= SUM;
            last_q <= in_last;
          end
        end
        SUM: begin
          acc <= nxt[ACC_W-1:0];
          ovf <= ovf | nxt[ACC_W];
          idx <= '0;
          slot <= '0;
          state <= last_q ? DONE : FILL;
        end
        DONE: if (out_ready) begin
          state <= FILL;
          acc <= '0;
          ovf <= 1'b0;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_four_operand_accum_seq.sv
// tb_four_operand_accum_seq: scoreboard bench comparing frame results against an integer sum model
module tb_four_operand_accum_seq;
  localparam int ACC_W = 12;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [5:0] in_data = 0;
  logic in_ready, out_valid, out_ovf;
  logic [ACC_W-1:0] out_sum;
  int checks = 0, failures = 0, cyc = 0, t_acc = 0, low_cnt = 0, model_sum = 0;
  int exp_q[$];
  bit rand_ready = 0, hold_v = 0;
  logic [ACC_W-1:0] hold_sum;
  logic hold_ovf;

  four_operand_accum_seq #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // monitor: pops expected totals at every result handshake
  always @(negedge clk) begin
    if (rst) hold_v = 0;
    else begin
      if (!in_ready) low_cnt++;
      chk("ready_valid_excl", int'(in_ready && out_valid), 0);
      if (hold_v && out_valid) begin
        chk("hold_sum", out_sum, hold_sum);
        chk("hold_ovf", out_ovf, hold_ovf);
      end
      hold_v = out_valid && !out_ready;
      hold_sum = out_sum;
      hold_ovf = out_ovf;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          int tot;
          tot = exp_q.pop_front();
          chk("out_sum", out_sum, tot % (1 << ACC_W));
          chk("out_ovf", out_ovf, int'(tot >= (1 << ACC_W)));
        end
      end
    end
  end

  task automatic send(input logic [5:0] d, input logic l);
    int n;
    logic ok;
    in_valid = 1;
    in_data = d;
    in_last = l;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    in_valid = 0;
    chk("accept_timeout", int'(ok), 1);
    if (ok) begin
      model_sum += d;
      t_acc = cyc;
      if (l) begin
        exp_q.push_back(model_sum);
        model_sum = 0;
      end
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk("valid_timeout", int'(out_valid), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    @(posedge clk);
    #1;
    out_ready = 1;
    // 10,20,30,40 with latency check
    send(10, 0); send(20, 0); send(30, 0); send(40, 1);
    wait_valid();
    chk("latency", cyc, t_acc + 1);
    drain();
    // two groups; in_ready low only in the two SUM cycles and DONE
    @(posedge clk);
    #1;
    low_cnt = 0;
    send(63, 0); send(63, 0); send(63, 0); send(63, 0); send(5, 0); send(6, 1);
    drain();
    @(posedge clk);
    #1;
    chk("in_ready_low_cycles", low_cnt, 3);
    // 68 beats of 63 wraps the 12-bit accumulator
    for (int i = 1; i <= 68; i++) send(63, i == 68);
    drain();
    // single beat with consumer stalled
    out_ready = 0;
    send(7, 1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", out_sum, 7);
      chk("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    drain();
    // reset mid-group discards the partial data
    send(9, 0); send(11, 0);
    model_sum = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    chk("mid_rst_out_ovf", out_ovf, 0);
    @(posedge clk);
    #1;
    send(1, 0); send(2, 1);
    drain();
    // random frames with gaps on both sides
    rand_ready = 1;
    for (int f = 0; f < 1000; f++) begin
      int len;
      bit big;
      big = ($urandom_range(0, 19) == 0);
      len = big ? $urandom_range(60, 80) : $urandom_range(1, 10);
      for (int b = 1; b <= len; b++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(big ? 6'd63 : 6'($urandom_range(0, 63)), b == len);
      end
    end
    drain();
    rand_ready = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
